// File: rtl/param_bus.sv
// Parameterised shared bus: round-robin master arbitration with optional hold limit,
// address-decoded slave select, one-cycle registered read return and decode-error pulse.
module param_bus #(
  parameter int unsigned N_M      = 2,
  parameter int unsigned N_S      = 2,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_M-1:0]    M_req,
  input  logic [N_M-1:0]    M_wr,
  input  logic [N_M*AW-1:0] M_address,
  input  logic [N_M*DW-1:0] M_dout,
  output logic [N_M-1:0]    M_grant,
  output logic [DW-1:0]     M_din,
  output logic [N_S-1:0]    S_sel,
  output logic [AW-1:0]     S_address,
  output logic              S_wr,
  output logic [DW-1:0]     S_din,
  input  logic [N_S*DW-1:0] S_dout,
  output logic              bus_err
);

  localparam int unsigned SW = $clog2(N_S);
  localparam int unsigned MW = $clog2(N_M);

  logic [N_M-1:0] grant_q, grant_d;
  logic [MW-1:0]  last_ptr_q, last_ptr_d;
  logic [31:0]    hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]  rd_idx_q;
  logic           rd_vld_q;
  logic           bus_err_q;

  logic [MW-1:0]  hold_idx;
  logic           grant_vld;
  logic [N_M-1:0] cand;
  logic           cand_found;
  logic [MW-1:0]  cand_idx;
  logic           hold_expired;

  logic [AW-1:0]  gnt_addr;
  logic           gnt_wr;
  logic [DW-1:0]  gnt_data;
  logic [SW-1:0]  slv_idx;
  logic [31:0]    slv_idx_ext;
  logic           idx_ok;

  always_comb begin
    hold_idx = '0;
    for (int i = 0; i < int'(N_M); i++) begin
      if (grant_q[i]) hold_idx = MW'(i);
    end
  end

  assign grant_vld = |grant_q;

  // Holder is masked out so a preemption never re-selects it; iterate backwards so the
  // nearest requester after last_ptr is the final assignment.
  always_comb begin
    cand       = M_req & ~grant_q;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = int'(N_M); k >= 1; k--) begin
      if (cand[(int'(last_ptr_q) + k) % int'(N_M)]) begin
        cand_found = 1'b1;
        cand_idx   = MW'((int'(last_ptr_q) + k) % int'(N_M));
      end
    end
  end

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD - 1);

  always_comb begin
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (!grant_vld || !M_req[hold_idx] || (hold_expired && cand_found)) begin
      grant_d    = '0;
      hold_cnt_d = '0;
      if (cand_found) begin
        grant_d[cand_idx] = 1'b1;
        last_ptr_d        = cand_idx;
      end
    end else if (!hold_expired && (hold_cnt_q != '1)) begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end
  end

  always_comb begin
    gnt_addr    = M_address[hold_idx*AW +: AW];
    gnt_wr      = M_wr[hold_idx];
    gnt_data    = M_dout[hold_idx*DW +: DW];
    slv_idx     = gnt_addr[AW-1 -: SW];
    slv_idx_ext = 32'(slv_idx);
    idx_ok      = slv_idx_ext < N_S;
  end

  always_comb begin
    S_sel     = '0;
    S_address = '0;
    S_wr      = 1'b0;
    S_din     = '0;
    if (grant_vld) begin
      S_address = gnt_addr;
      S_din     = gnt_data;
      S_wr      = gnt_wr & idx_ok;
      for (int j = 0; j < int'(N_S); j++) begin
        S_sel[j] = idx_ok && (slv_idx_ext == 32'(j));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= '0;
      last_ptr_q <= MW'(N_M - 1);
      hold_cnt_q <= '0;
      rd_idx_q   <= '0;
      rd_vld_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      bus_err_q  <= grant_vld & ~idx_ok;
      if (grant_vld && !gnt_wr && idx_ok) begin
        rd_idx_q <= slv_idx;
        rd_vld_q <= 1'b1;
      end else begin
        rd_vld_q <= 1'b0;
      end
    end
  end

  assign M_grant = grant_q;
  assign bus_err = bus_err_q;
  assign M_din   = rd_vld_q ? S_dout[rd_idx_q*DW +: DW] : '0;

endmodule

// File: tb/tb_param_bus.sv
// Scoreboard bench for param_bus: three configurations driven cycle by cycle, expected
// values queued per cycle and checked by an independent negedge monitor.
module tb_param_bus;

  localparam int A_GNT = 0, A_SEL = 1, A_WR = 2, A_ADR = 3, A_DIN = 4, A_MDIN = 5,
                 A_ERR = 6, B_GNT = 7, C_SEL = 8, C_WR = 9, C_ERR = 10, C_GNT = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic clk;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  // Instance A: 2 masters, 2 slaves, unlimited hold
  logic        rst_a;
  logic [1:0]  a_req, a_wr, a_grant, a_sel;
  logic [15:0] a_addr, a_dout, a_sdout;
  logic [7:0]  a_mdin, a_saddr, a_sdin;
  logic        a_swr, a_err;

  // Instance B: 4 masters, hold limit 3
  logic        rst_b;
  logic [3:0]  b_req, b_wr, b_grant;
  logic [31:0] b_addr, b_dout;
  logic [15:0] b_sdout;
  logic [7:0]  b_mdin, b_saddr, b_sdin;
  logic [1:0]  b_sel;
  logic        b_swr, b_err;

  // Instance C: 2 masters, 3 slaves (index 3 is undecoded)
  logic        rst_c;
  logic [1:0]  c_req, c_wr, c_grant;
  logic [15:0] c_addr, c_dout;
  logic [23:0] c_sdout;
  logic [7:0]  c_mdin, c_saddr, c_sdin;
  logic [2:0]  c_sel;
  logic        c_swr, c_err;

  param_bus #(.N_M(2), .N_S(2), .AW(8), .DW(8), .MAX_HOLD(0)) u_a (
    .clk(clk), .reset(rst_a), .M_req(a_req), .M_wr(a_wr), .M_address(a_addr),
    .M_dout(a_dout), .M_grant(a_grant), .M_din(a_mdin), .S_sel(a_sel),
    .S_address(a_saddr), .S_wr(a_swr), .S_din(a_sdin), .S_dout(a_sdout), .bus_err(a_err)
  );

  param_bus #(.N_M(4), .N_S(2), .AW(8), .DW(8), .MAX_HOLD(3)) u_b (
    .clk(clk), .reset(rst_b), .M_req(b_req), .M_wr(b_wr), .M_address(b_addr),
    .M_dout(b_dout), .M_grant(b_grant), .M_din(b_mdin), .S_sel(b_sel),
    .S_address(b_saddr), .S_wr(b_swr), .S_din(b_sdin), .S_dout(b_sdout), .bus_err(b_err)
  );

  param_bus #(.N_M(2), .N_S(3), .AW(8), .DW(8), .MAX_HOLD(0)) u_c (
    .clk(clk), .reset(rst_c), .M_req(c_req), .M_wr(c_wr), .M_address(c_addr),
    .M_dout(c_dout), .M_grant(c_grant), .M_din(c_mdin), .S_sel(c_sel),
    .S_address(c_saddr), .S_wr(c_swr), .S_din(c_sdin), .S_dout(c_sdout), .bus_err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      A_GNT:   return 32'(a_grant);
      A_SEL:   return 32'(a_sel);
      A_WR:    return 32'(a_swr);
      A_ADR:   return 32'(a_saddr);
      A_DIN:   return 32'(a_sdin);
      A_MDIN:  return 32'(a_mdin);
      A_ERR:   return 32'(a_err);
      B_GNT:   return 32'(b_grant);
      C_SEL:   return 32'(c_sel);
      C_WR:    return 32'(c_swr);
      C_ERR:   return 32'(c_err);
      C_GNT:   return 32'(c_grant);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      A_GNT:   return "a_grant";
      A_SEL:   return "a_s_sel";
      A_WR:    return "a_s_wr";
      A_ADR:   return "a_s_address";
      A_DIN:   return "a_s_din";
      A_MDIN:  return "a_m_din";
      A_ERR:   return "a_bus_err";
      B_GNT:   return "b_grant";
      C_SEL:   return "c_s_sel";
      C_WR:    return "c_s_wr";
      C_ERR:   return "c_bus_err";
      C_GNT:   return "c_grant";
      default: return "unknown";
    endcase
  endfunction

  task automatic push_exp(int s, logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: retire every expectation due this cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        logic [31:0] act;
        act = get_sig(exp_q[i].sig);
        vectors++;
        if (act !== exp_q[i].val) begin
          miscompares++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", sig_name(exp_q[i].sig),
                   cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL stale_%s cyc=%0d actual=unchecked required=%0h",
                 sig_name(exp_q[i].sig), exp_q[i].cyc, exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  task automatic step();
    case (cyc)
      1: begin
        rst_a = 1'b0; a_req = 2'b11;
        push_exp(A_GNT, 0); push_exp(A_MDIN, 0); push_exp(A_SEL, 0);
        push_exp(A_ADR, 0); push_exp(A_ERR, 0);
        rst_c = 1'b0; c_req = 2'b01; c_wr = 2'b01; c_addr = 16'h00C0; c_dout = 16'h00FF;
        push_exp(C_GNT, 0); push_exp(C_ERR, 0);
      end
      2: begin
        push_exp(A_GNT, 32'b01);
        push_exp(C_GNT, 32'b01); push_exp(C_SEL, 0); push_exp(C_WR, 0); push_exp(C_ERR, 0);
      end
      3: begin
        push_exp(A_GNT, 32'b01);
        a_req = 2'b10;
        c_addr = 16'h0040;
        push_exp(C_ERR, 1); push_exp(C_SEL, 32'b010); push_exp(C_WR, 1);
      end
      4: begin
        push_exp(A_GNT, 32'b10);
        a_wr = 2'b10; a_addr = 16'h8500; a_dout = 16'h3C11;
        push_exp(A_SEL, 32'b10); push_exp(A_WR, 1);
        push_exp(A_ADR, 32'h85); push_exp(A_DIN, 32'h3C);
        c_addr = 16'h0080;
        push_exp(C_ERR, 0); push_exp(C_SEL, 32'b100);
      end
      5: begin
        a_addr = 16'h0500; a_wr = 2'b00; a_req = 2'b00; a_sdout = 16'h5AA5;
        push_exp(A_SEL, 32'b01); push_exp(A_WR, 0); push_exp(A_MDIN, 0);
        push_exp(A_ADR, 32'h05);
        c_req = 2'b00;
      end
      6: begin
        push_exp(A_MDIN, 32'hA5); push_exp(A_GNT, 0); push_exp(A_SEL, 0);
        push_exp(A_ADR, 0); push_exp(A_DIN, 0); push_exp(A_WR, 0);
      end
      7: begin
        push_exp(A_MDIN, 0);
        a_req = 2'b10;
      end
      8: push_exp(A_GNT, 32'b10);
      9: begin
        push_exp(A_MDIN, 32'hA5);
        rst_a = 1'b1; a_req = 2'b11;
      end
      10: begin
        push_exp(A_GNT, 0); push_exp(A_MDIN, 0);
        rst_a = 1'b0;
      end
      11: push_exp(A_GNT, 32'b01);
      default: ;
    endcase
    // B: all four masters request continuously; each tenure lasts three cycles
    if (cyc == 1) begin
      rst_b = 1'b0; b_req = 4'hF;
      push_exp(B_GNT, 0);
    end else if (cyc >= 2 && cyc <= 14) begin
      push_exp(B_GNT, 32'(1 << (((cyc - 2) / 3) % 4)));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    a_req = '0; a_wr = '0; a_addr = '0; a_dout = '0; a_sdout = '0;
    b_req = '0; b_wr = '0; b_addr = '0; b_dout = '0; b_sdout = '0;
    c_req = '0; c_wr = '0; c_addr = '0; c_dout = '0; c_sdout = 24'h332211;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      step();
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
